// File: rtl/io_input_conditioner.sv
// Board input conditioner: N-stage synchronisers for switches and buttons, per-button
// debounce with rise/fall pulses, sticky pending flags and a switch snapshot on press.
module io_input_conditioner #(
  parameter int SW_WIDTH        = 8,
  parameter int BTN_COUNT       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  Switches,
  input  logic [BTN_COUNT-1:0] Button,
  input  logic [BTN_COUNT-1:0] btn_ack,
  output logic [SW_WIDTH-1:0]  sw_sync,
  output logic [SW_WIDTH-1:0]  sw_snap,
  output logic [BTN_COUNT-1:0] btn_level,
  output logic [BTN_COUNT-1:0] btn_rise,
  output logic [BTN_COUNT-1:0] btn_fall,
  output logic [BTN_COUNT-1:0] btn_pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_chain  [SYNC_STAGES];
  logic [BTN_COUNT-1:0] btn_chain [SYNC_STAGES];
  logic [CW-1:0]        cnt       [BTN_COUNT];
  logic [BTN_COUNT-1:0] btn_synced;
  logic [BTN_COUNT-1:0] flip;
  logic [BTN_COUNT-1:0] rise_next;
  logic [BTN_COUNT-1:0] fall_next;

  assign sw_sync    = sw_chain[SYNC_STAGES-1];
  assign btn_synced = btn_chain[SYNC_STAGES-1];

  // A channel flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    flip = '0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      flip[i] = (btn_synced[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
    rise_next = flip & ~btn_level;
    fall_next = flip & btn_level;
  end

  // btn_ack is a level: while high it clears pending, except on the cycle a new
  // rise is being registered, where the rise wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sw_chain[s]  <= '0;
        btn_chain[s] <= '0;
      end
      for (int i = 0; i < BTN_COUNT; i++) cnt[i] <= '0;
      sw_snap     <= '0;
      btn_level   <= '0;
      btn_rise    <= '0;
      btn_fall    <= '0;
      btn_pending <= '0;
    end else begin
      sw_chain[0]  <= Switches;
      btn_chain[0] <= Button;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sw_chain[s]  <= sw_chain[s-1];
        btn_chain[s] <= btn_chain[s-1];
      end
      for (int i = 0; i < BTN_COUNT; i++) begin
        if (btn_synced[i] == btn_level[i] || flip[i]) cnt[i] <= '0;
        else                                          cnt[i] <= cnt[i] + CW'(1);
      end
      btn_level   <= btn_level ^ flip;
      btn_rise    <= rise_next;
      btn_fall    <= fall_next;
      btn_pending <= rise_next | (btn_pending & ~btn_ack);
      if (|rise_next) sw_snap <= sw_sync;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench: a 4-channel instance with a short debounce window and a
// 1-channel instance with the default 20-cycle window.
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Switches;
  logic [3:0] Button;
  logic [3:0] btn_ack;
  logic [7:0] sw_sync, sw_snap;
  logic [3:0] btn_level, btn_rise, btn_fall, btn_pending;

  logic       button20, ack20;
  logic [7:0] sw_sync20, sw_snap20;
  logic       level20, rise20, fall20, pending20;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(.SW_WIDTH(8), .BTN_COUNT(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .Switches(Switches), .Button(Button), .btn_ack(btn_ack),
    .sw_sync(sw_sync), .sw_snap(sw_snap), .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .btn_pending(btn_pending)
  );

  io_input_conditioner #(.SW_WIDTH(8), .BTN_COUNT(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(20)) dut20 (
    .clk(clk), .rst(rst), .Switches(Switches), .Button(button20), .btn_ack(ack20),
    .sw_sync(sw_sync20), .sw_snap(sw_snap20), .btn_level(level20), .btn_rise(rise20),
    .btn_fall(fall20), .btn_pending(pending20)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; Switches = 8'hFF; Button = 4'hF; btn_ack = 4'h0; button20 = 1'b1; ack20 = 1'b0;
    tick(4);
    checks++;
    if ({sw_sync, sw_snap, btn_level, btn_rise, btn_fall, btn_pending} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got sync=%h snap=%h lvl=%b rise=%b fall=%b pend=%b, need all 0",
               sw_sync, sw_snap, btn_level, btn_rise, btn_fall, btn_pending);
    end
    checks++;
    if ({sw_sync20, sw_snap20, level20, rise20, fall20, pending20} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs20: got sync=%h lvl=%b pend=%b, need 0", sw_sync20, level20, pending20);
    end
    rst = 1'b1; Button = 4'h0; button20 = 1'b0;
    tick(1);
    checks++;
    if (sw_sync !== 8'h00) begin
      errors++; $display("FAIL reset_release_1: sw_sync=%h need 00", sw_sync);
    end
    tick(1);
    checks++;
    if (sw_sync !== 8'hFF) begin
      errors++; $display("FAIL reset_release_2: sw_sync=%h need ff", sw_sync);
    end
    tick(4);
  endtask

  task automatic test_switch_sync();
    Switches = 8'h15;
    tick(3);
    Switches = 8'h6D;
    tick(1);
    checks++;
    if (sw_sync !== 8'h15) begin
      errors++; $display("FAIL sw_sync_hold: sw_sync=%h need 15", sw_sync);
    end
    tick(1);
    checks++;
    if (sw_sync !== 8'h6D) begin
      errors++; $display("FAIL sw_sync_latency: sw_sync=%h need 6d", sw_sync);
    end
  endtask

  task automatic test_glitch_reject();
    logic seen_rise;
    seen_rise = 1'b0;
    button20 = 1'b1;
    for (int k = 0; k < 19; k++) begin
      tick(1);
      seen_rise |= rise20;
    end
    button20 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      seen_rise |= rise20 | level20;
    end
    checks++;
    if (seen_rise !== 1'b0 || level20 !== 1'b0 || pending20 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_19: seen_rise=%b level=%b pending=%b need 0 0 0", seen_rise, level20, pending20);
    end
    // Exactly 20 cycles high is accepted: level at 2+20 edges after the raw rise.
    button20 = 1'b1;
    tick(21);
    checks++;
    if (level20 !== 1'b0) begin
      errors++; $display("FAIL accept_20_early: level=%b need 0", level20);
    end
    tick(1);
    checks++;
    if (level20 !== 1'b1 || rise20 !== 1'b1 || pending20 !== 1'b1) begin
      errors++; $display("FAIL accept_20: level=%b rise=%b pending=%b need 1 1 1", level20, rise20, pending20);
    end
    button20 = 1'b0; ack20 = 1'b1;
    tick(25);
    ack20 = 1'b0;
  endtask

  task automatic test_clean_press();
    Button = 4'b0001;
    tick(5);
    checks++;
    if (btn_level !== 4'b0000 || btn_rise !== 4'b0000) begin
      errors++; $display("FAIL press_early: level=%b rise=%b need 0000 0000", btn_level, btn_rise);
    end
    tick(1);
    checks++;
    if (btn_level !== 4'b0001 || btn_rise !== 4'b0001 || btn_pending !== 4'b0001 || sw_snap !== 8'h6D) begin
      errors++;
      $display("FAIL press_rise: level=%b rise=%b pend=%b snap=%h need 0001 0001 0001 6d",
               btn_level, btn_rise, btn_pending, sw_snap);
    end
    tick(1);
    checks++;
    if (btn_rise !== 4'b0000 || btn_level !== 4'b0001) begin
      errors++; $display("FAIL press_pulse_width: rise=%b level=%b need 0000 0001", btn_rise, btn_level);
    end
    tick(8);
    Button = 4'b0000;
    tick(5);
    checks++;
    if (btn_fall !== 4'b0000 || btn_level !== 4'b0001) begin
      errors++; $display("FAIL release_early: fall=%b level=%b need 0000 0001", btn_fall, btn_level);
    end
    tick(1);
    checks++;
    if (btn_fall !== 4'b0001 || btn_level !== 4'b0000 || btn_rise !== 4'b0000) begin
      errors++; $display("FAIL release_fall: fall=%b level=%b rise=%b need 0001 0000 0000", btn_fall, btn_level, btn_rise);
    end
    tick(1);
    checks++;
    if (btn_fall !== 4'b0000) begin
      errors++; $display("FAIL fall_pulse_width: fall=%b need 0000", btn_fall);
    end
    tick(8);
  endtask

  task automatic test_pending_ack();
    btn_ack = 4'b0001;
    tick(1);
    checks++;
    if (btn_pending !== 4'b0000) begin
      errors++; $display("FAIL ack_clear: pending=%b need 0000", btn_pending);
    end
    tick(1);
    checks++;
    if (btn_pending !== 4'b0000) begin
      errors++; $display("FAIL ack_idle: pending=%b need 0000", btn_pending);
    end
    btn_ack = 4'b0000;
    Button = 4'b0001;
    tick(5);
    btn_ack = 4'b0001;
    tick(1);
    checks++;
    if (btn_rise !== 4'b0001 || btn_pending !== 4'b0001) begin
      errors++; $display("FAIL ack_with_rise: rise=%b pending=%b need 0001 0001", btn_rise, btn_pending);
    end
    tick(1);
    checks++;
    if (btn_pending !== 4'b0000) begin
      errors++; $display("FAIL ack_held: pending=%b need 0000", btn_pending);
    end
    btn_ack = 4'b0000;
    Button = 4'b0000;
    tick(10);
  endtask

  task automatic test_multi_channel();
    Switches = 8'h15;
    tick(3);
    Button = 4'b0101;
    tick(6);
    checks++;
    if (btn_rise !== 4'b0101 || btn_pending !== 4'b0101 || sw_snap !== 8'h15) begin
      errors++;
      $display("FAIL multi_rise: rise=%b pend=%b snap=%h need 0101 0101 15", btn_rise, btn_pending, sw_snap);
    end
    Switches = 8'hA3;
    btn_ack = 4'b0001;
    tick(1);
    checks++;
    if (btn_pending !== 4'b0100 || btn_rise !== 4'b0000) begin
      errors++; $display("FAIL multi_ack: pending=%b rise=%b need 0100 0000", btn_pending, btn_rise);
    end
    btn_ack = 4'b0000;
    tick(4);
    checks++;
    if (sw_snap !== 8'h15 || sw_sync !== 8'hA3) begin
      errors++; $display("FAIL snap_hold: snap=%h sync=%h need 15 a3", sw_snap, sw_sync);
    end
    Button = 4'b0000;
    tick(6);
    checks++;
    if (btn_fall !== 4'b0101 || btn_level !== 4'b0000) begin
      errors++; $display("FAIL multi_fall: fall=%b level=%b need 0101 0000", btn_fall, btn_level);
    end
    tick(3);
  endtask

  initial begin
    test_reset();
    test_switch_sync();
    test_glitch_reject();
    test_clean_press();
    test_pending_ack();
    test_multi_channel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
